// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between a group of four requesters and the
// round-robin arbiter.
//   i_req       : request vector, bit k = requester k wants the resource
//   o_grant     : one-hot grant, 4'b0000 when nobody owns the resource
//   o_grant_idx : binary index of the current owner (valid with o_valid)
//   o_valid     : a grant is active this cycle
//   o_timeout   : one-cycle pulse after an owner was forcibly released
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter_4_if;
  logic [3:0] i_req;
  logic [3:0] o_grant;
  logic [1:0] o_grant_idx;
  logic       o_valid;
  logic       o_timeout;

  modport master (
    output i_req,
    input  o_grant,
    input  o_grant_idx,
    input  o_valid,
    input  o_timeout
  );

  modport slave (
    input  i_req,
    output o_grant,
    output o_grant_idx,
    output o_valid,
    output o_timeout
  );
endinterface

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter sharing one resource between four requesters.
// One requester owns the resource at a time; ownership lasts until the owner
// drops its request or has held it for MAX_HOLD cycles (0 = no limit).
// Every grant is followed by at least one idle cycle, and the next
// arbitration starts searching just past the previous owner.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : asynchronous reset, active-high
//   bus     : rr_arbiter_4_if.slave (i_req in; o_grant, o_grant_idx,
//             o_valid, o_timeout out, all driven from registers)

// 2-to-4 one-hot decoder with enable.
// Ports: i_sel (binary select), i_en (enable), o_dec (one-hot output).
module decoder_2_4 (
  input  logic [1:0] i_sel,
  input  logic       i_en,
  output logic [3:0] o_dec
);
  // Decode the select into a one-hot vector; all zeros when disabled
  always_comb begin
    o_dec = 4'b0000;
    if (i_en) begin
      case (i_sel)
        2'd0:    o_dec = 4'b0001;
        2'd1:    o_dec = 4'b0010;
        2'd2:    o_dec = 4'b0100;
        2'd3:    o_dec = 4'b1000;
        default: o_dec = 4'b0000;
      endcase
    end else begin
      o_dec = 4'b0000;
    end
  end
endmodule

module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic           i_clk,
  input  logic           i_reset,
  rr_arbiter_4_if.slave  bus
);

  localparam int unsigned CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [1:0]       ptr_r, ptr_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [1:0]       idx_r, idx_s;
  logic             valid_r, valid_s;
  logic             timeout_r, timeout_s;
  logic [2:0]       pick_s;
  logic [3:0]       grant_s;

  // Returns {found, index} of the first requester in order ptr, ptr+1, ...
  // Scanning from the farthest offset down lets the nearest one win.
  function automatic logic [2:0] pick_owner(input logic [3:0] req,
                                            input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Priority search for the next owner
  always_comb begin
    pick_s = pick_owner(bus.i_req, ptr_r);
  end

  // Next-state and next-output logic
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    valid_s   = valid_r;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_s[2]) begin
          state_s = GRANT;
          idx_s   = pick_s[1:0];
          ptr_s   = pick_s[1:0] + 2'd1;
          cnt_s   = CNT_ONE;
          valid_s = 1'b1;
        end else begin
          valid_s = 1'b0;
        end
      end
      GRANT: begin
        if (!bus.i_req[idx_r]) begin
          // Release wins over a coincident timeout, so no pulse here
          state_s = IDLE;
          valid_s = 1'b0;
        end else if ((MAX_HOLD != 0) && (cnt_r == CNT_MAX)) begin
          state_s   = IDLE;
          valid_s   = 1'b0;
          timeout_s = 1'b1;
        end else if (cnt_r != CNT_MAX) begin
          cnt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r   <= IDLE;
      ptr_r     <= 2'd0;
      cnt_r     <= '0;
      idx_r     <= 2'd0;
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      valid_r   <= valid_s;
      timeout_r <= timeout_s;
    end
  end

  // One-hot grant is a pure decode of registered index and valid
  decoder_2_4 u_dec (
    .i_sel (idx_r),
    .i_en  (valid_r),
    .o_dec (grant_s)
  );

  assign bus.o_grant     = grant_s;
  assign bus.o_grant_idx = idx_r;
  assign bus.o_valid     = valid_r;
  assign bus.o_timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arbiter_4.sv
module tb_rr_arbiter_4;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       valid;
    logic       timeout;
    logic       chk_idx;
  } vec_t;

  logic i_clk;
  logic i_reset;
  int   n_vec;
  int   n_bad;
  vec_t vq[$];

  rr_arbiter_4_if bus ();

  rr_arbiter_4 #(.MAX_HOLD(3)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] grant,
                     input logic [1:0] idx, input logic valid, input logic timeout,
                     input logic chk_idx);
    vq.push_back('{rst, req, grant, idx, valid, timeout, chk_idx});
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] ei,
                       input logic ev, input logic et, input logic ci);
    n_vec++;
    if (bus.o_grant !== eg || bus.o_valid !== ev || bus.o_timeout !== et ||
        (ci && bus.o_grant_idx !== ei)) begin
      n_bad++;
      $display("FAIL %s: got grant=%b idx=%0d valid=%b timeout=%b, expected grant=%b idx=%0d valid=%b timeout=%b",
               name, bus.o_grant, bus.o_grant_idx, bus.o_valid, bus.o_timeout, eg, ei, ev, et);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    i_reset = 1'b1;
    bus.i_req = 4'b1111;

    // Reset held with all requests active
    for (int i = 0; i < 5; i++) add(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    // Single requester 2, released after two cycles
    add(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    // Owner 3 releases, then 1001 must pick 0 (ptr wrapped)
    add(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    // Reset, then full rotation under constant 1111 with timeouts
    add(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] g;
      g = 4'b0001 << k;
      for (int c = 0; c < 3; c++) add(1'b0, 4'b1111, g, 2'(k), 1'b1, 1'b0, 1'b1);
      add(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
    end
    add(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    // Release on the same edge the hold limit is reached: no timeout pulse
    for (int c = 0; c < 3; c++) add(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    // Lone requester times out and is re-granted after the idle cycle
    for (int c = 0; c < 3; c++) add(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge i_clk);
      i_reset   = vq[i].rst;
      bus.i_req = vq[i].req;
      @(posedge i_clk);
      #1;
      check($sformatf("vec%0d", i), vq[i].grant, vq[i].idx, vq[i].valid,
            vq[i].timeout, vq[i].chk_idx);
    end

    // Asynchronous reset between edges during grant 0100
    @(negedge i_clk);
    i_reset   = 1'b0;
    bus.i_req = 4'b0100;
    @(posedge i_clk);
    #1;
    check("async_pre", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
    #2;
    i_reset = 1'b1;
    #1;
    check("async_drop", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    @(negedge i_clk);
    i_reset   = 1'b0;
    bus.i_req = 4'b1111;
    @(posedge i_clk);
    #1;
    check("after_reset_ptr0", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
